// File: rtl/wless_tx_buffer_pkg.sv
// rtl/wless_tx_buffer_pkg.sv - shared defaults and FSM encoding for the wireless TX buffer
package wless_tx_buffer_pkg;

    localparam int DEF_DATA_WIDTH        = 8;
    localparam int DEF_FIFO_DEPTH        = 512;
    localparam int DEF_START_TRANS_LEVEL = 58;
    localparam int DEF_IDLE_TIMEOUT      = 200000;
    localparam int FILL_W                = 10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_WAIT_ACK = 2'd3
    } tx_state_t;

endpackage

// File: rtl/sync_fifo_512.sv
// rtl/sync_fifo_512.sv - single-clock byte FIFO with occupancy count
module sync_fifo_512 #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 512
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [DATA_WIDTH-1:0]         din,
    output logic [DATA_WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(DEPTH):0]        count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is still taken when a pop frees the slot this cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/wless_tx_buffer.sv
// rtl/wless_tx_buffer.sv - collects MCU bytes and drains them in bursts to the node UART
module wless_tx_buffer
    import wless_tx_buffer_pkg::*;
#(
    parameter int DATA_WIDTH                  = DEF_DATA_WIDTH,
    parameter int FIFO512_DEPTH               = DEF_FIFO_DEPTH,
    parameter int START_WIRELESS_TRANS_VALUE  = DEF_START_TRANS_LEVEL,
    parameter int END_WAITING_SEND_WLESS_DATA = DEF_IDLE_TIMEOUT
) (
    input  logic                  internal_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_from_uart_mcu,
    input  logic                  RX_flag_mcu,
    output logic [DATA_WIDTH-1:0] data_to_uart_node,
    output logic                  TX_use_node,
    input  logic                  TX_flag_node,
    output logic                  AUX,
    output logic [FILL_W-1:0]     fill_level,
    output logic                  overflow
);
    localparam int CW  = $clog2(FIFO512_DEPTH) + 1;
    localparam int ICW = $clog2(END_WAITING_SEND_WLESS_DATA) + 1;
    localparam logic [FILL_W-1:0] START_LVL = FILL_W'(START_WIRELESS_TRANS_VALUE);
    localparam logic [ICW-1:0]    IDLE_LAST = ICW'(END_WAITING_SEND_WLESS_DATA - 1);

    tx_state_t             state;
    tx_state_t             state_next;
    logic [ICW-1:0]        idle_cnt;
    logic [CW-1:0]         fifo_count;
    logic [CW-1:0]         count_next;
    logic [DATA_WIDTH-1:0] head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;
    logic                  push_ok;

    sync_fifo_512 #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO512_DEPTH)
    ) u_fifo (
        .clk   (internal_clk),
        .rst   (rst),
        .push  (RX_flag_mcu),
        .pop   (fifo_pop),
        .din   (data_from_uart_mcu),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fill_level = FILL_W'(fifo_count);
    assign push_ok    = RX_flag_mcu && (!fifo_full || fifo_pop);

    always_ff @(posedge internal_clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:     if (push_ok || !fifo_empty) state_next = ST_COLLECT;
            ST_COLLECT:  if (fill_level >= START_LVL || idle_cnt == IDLE_LAST) state_next = ST_DRAIN;
            // A byte landing in the last empty DRAIN cycle keeps the burst alive.
            ST_DRAIN:    if (fifo_empty && !RX_flag_mcu) state_next = ST_IDLE;
                         else if (!fifo_empty && !TX_flag_node) state_next = ST_WAIT_ACK;
            ST_WAIT_ACK: state_next = ST_DRAIN;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        fifo_pop   = (state == ST_DRAIN) && !fifo_empty && !TX_flag_node;
        count_next = fifo_count;
        if (push_ok && !fifo_pop)      count_next = fifo_count + 1'b1;
        else if (!push_ok && fifo_pop) count_next = fifo_count - 1'b1;
    end

    always_ff @(posedge internal_clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (state_next != ST_COLLECT || RX_flag_mcu) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge internal_clk or posedge rst) begin
        if (rst) begin
            TX_use_node       <= 1'b0;
            data_to_uart_node <= '0;
            overflow          <= 1'b0;
            AUX               <= 1'b1;
        end else begin
            TX_use_node <= fifo_pop;
            if (fifo_pop) data_to_uart_node <= head;
            if (RX_flag_mcu && fifo_full && !fifo_pop) overflow <= 1'b1;
            AUX <= (state_next == ST_IDLE) && (count_next == '0);
        end
    end

endmodule

// File: tb/tb_wless_tx_buffer.sv
// tb/tb_wless_tx_buffer.sv - scoreboard bench for wless_tx_buffer
module tb_wless_tx_buffer;
    localparam int DEPTH   = 16;
    localparam int THRESH  = 4;
    localparam int TIMEOUT = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       rx  = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] dout;
    logic       tx_use;
    logic       aux;
    logic [9:0] fill;
    logic       ovf;

    wless_tx_buffer #(
        .DATA_WIDTH                  (8),
        .FIFO512_DEPTH               (DEPTH),
        .START_WIRELESS_TRANS_VALUE  (THRESH),
        .END_WAITING_SEND_WLESS_DATA (TIMEOUT)
    ) dut (
        .internal_clk       (clk),
        .rst                (rst),
        .data_from_uart_mcu (din),
        .RX_flag_mcu        (rx),
        .data_to_uart_node  (dout),
        .TX_use_node        (tx_use),
        .TX_flag_node       (tx_busy),
        .AUX                (aux),
        .fill_level         (fill),
        .overflow           (ovf)
    );

    always #5 clk = ~clk;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         cyc = 0;
    int         pulse_cnt = 0;
    int         last_pulse_cyc = 0;
    bit         have_prev = 1'b0;
    bit         gap_chk_en = 1'b0;
    bit         prev_pulse = 1'b0;
    logic       flag_at_edge = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic [7:0] exp_q[$];

    task automatic check(input bit ok, input string name, input int act, input int exp);
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    endtask

    always @(posedge clk) begin
        cyc          <= cyc + 1;
        flag_at_edge <= tx_busy;
    end

    // Monitor: every pulse must carry the oldest byte still owed to the node.
    always @(negedge clk) begin
        if (rst) begin
            last_data  = 8'h00;
            prev_pulse = 1'b0;
        end else begin
            if (tx_use) begin
                pulse_cnt++;
                check(!flag_at_edge, "tx_while_busy", int'(flag_at_edge), 0);
                check(!prev_pulse, "pulse_width", int'(prev_pulse), 0);
                if (gap_chk_en && have_prev)
                    check(cyc - last_pulse_cyc == 2, "pulse_gap", cyc - last_pulse_cyc, 2);
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_pulse", int'(dout), -1);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check(dout == e, "tx_data", int'(dout), int'(e));
                end
                last_pulse_cyc = cyc;
                have_prev      = 1'b1;
                last_data      = dout;
            end else begin
                check(dout == last_data, "data_stable", int'(dout), int'(last_data));
            end
            prev_pulse = tx_use;
        end
    end

    task automatic write_byte(input logic [7:0] b, input bit with_pop);
        @(negedge clk);
        din = b;
        rx  = 1'b1;
        @(posedge clk);
        if (exp_q.size() < DEPTH || with_pop) exp_q.push_back(b);
        #1 rx = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b0;
        tx_busy = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        have_prev = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && aux) break;
        end
        #1;
        check(exp_q.size() == 0, "drain_complete", exp_q.size(), 0);
        check(aux == 1'b1, "aux_idle", int'(aux), 1);
        check(fill == 10'd0, "fill_empty", int'(fill), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int p0;
        bit got;

        repeat (2) @(negedge clk);
        #1;
        check(aux == 1'b1, "reset_aux", int'(aux), 1);
        check(fill == 10'd0, "reset_fill", int'(fill), 0);
        check(tx_use == 1'b0, "reset_tx_use", int'(tx_use), 0);
        check(ovf == 1'b0, "reset_overflow", int'(ovf), 0);
        check(dout == 8'h00, "reset_data", int'(dout), 0);
        @(negedge clk);
        rst = 1'b0;

        // Four-byte burst at the threshold, node always ready.
        gap_chk_en = 1'b1;
        have_prev  = 1'b0;
        write_byte(8'h11, 1'b0);
        write_byte(8'h22, 1'b0);
        write_byte(8'h33, 1'b0);
        write_byte(8'h44, 1'b0);
        wait_idle(100);
        gap_chk_en = 1'b0;

        // Single byte only leaves through the idle timeout.
        p0 = pulse_cnt;
        write_byte(8'hA5, 1'b0);
        c0 = cyc;
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            #1;
            if (pulse_cnt != p0) got = 1'b1;
        end
        check(got, "timeout_pulse_seen", int'(got), 1);
        check(last_pulse_cyc - c0 >= TIMEOUT && last_pulse_cyc - c0 <= TIMEOUT + 3,
              "timeout_latency", last_pulse_cyc - c0, TIMEOUT + 1);
        wait_idle(100);

        // Overfill while the node is busy: 17th byte is dropped.
        tx_busy = 1'b1;
        for (int i = 0; i < 17; i++) write_byte(8'(8'h40 + i), 1'b0);
        check(fill == 10'd16, "full_fill", int'(fill), 16);
        check(ovf == 1'b1, "overflow_set", int'(ovf), 1);
        repeat (3) @(negedge clk);
        tx_busy = 1'b0;
        wait_idle(200);
        check(ovf == 1'b1, "overflow_sticky", int'(ovf), 1);

        // Busy window in the middle of a drain.
        do_reset();
        for (int i = 0; i < 8; i++) write_byte(8'(8'h80 + i), 1'b0);
        @(negedge clk);
        tx_busy = 1'b1;
        repeat (10) @(negedge clk);
        tx_busy = 1'b0;
        wait_idle(200);

        // Write coinciding with a pop at full.
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'(8'hC0 + i), 1'b0);
        check(fill == 10'd16, "prefull_fill", int'(fill), 16);
        tx_busy = 1'b0;
        write_byte(8'h5A, 1'b1);
        check(fill == 10'd16, "push_pop_fill", int'(fill), 16);
        check(ovf == 1'b0, "push_pop_no_ovf", int'(ovf), 0);
        wait_idle(200);

        // Reset while waiting for the ack with bytes still queued.
        do_reset();
        tx_busy = 1'b1;
        for (int i = 0; i < 4; i++) write_byte(8'(8'hE0 + i), 1'b0);
        p0 = pulse_cnt;
        tx_busy = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            #1;
            if (pulse_cnt != p0) got = 1'b1;
        end
        check(got, "pre_reset_pulse", int'(got), 1);
        rst = 1'b1;
        #1;
        check(fill == 10'd0, "mid_reset_fill", int'(fill), 0);
        check(aux == 1'b1, "mid_reset_aux", int'(aux), 1);
        check(tx_use == 1'b0, "mid_reset_tx_use", int'(tx_use), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        p0 = pulse_cnt;
        repeat (40) @(negedge clk);
        check(pulse_cnt == p0, "no_pulse_after_reset", pulse_cnt - p0, 0);

        // Random traffic with a randomly busy node.
        for (int i = 0; i < 400; i++) begin
            bit do_wr;
            @(negedge clk);
            tx_busy = ($urandom_range(0, 3) == 0);
            do_wr = ($urandom_range(0, 2) == 0) && (exp_q.size() < DEPTH - 2);
            rx  = do_wr;
            din = 8'($urandom);
            @(posedge clk);
            if (do_wr) exp_q.push_back(din);
        end
        @(negedge clk);
        rx = 1'b0;
        tx_busy = 1'b0;
        wait_idle(500);
        check(ovf == 1'b0, "random_no_ovf", int'(ovf), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wless_tx_buffer.md
WLESS_TX_BUFFER -- requirements
Module: wless_tx_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width.
REQ-002 SHALL have parameter FIFO512_DEPTH, default 512, buffer depth in bytes (power of 2).
REQ-003 SHALL have parameter START_WIRELESS_TRANS_VALUE, default 58, fill level that starts a drain.
REQ-004 SHALL have parameter END_WAITING_SEND_WLESS_DATA, default 200000, idle cycles that force a drain.
REQ-005 SHALL have ports:
- internal_clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- data_from_uart_mcu  in  DATA_WIDTH  received MCU byte.
- RX_flag_mcu  in  1  one-cycle pulse, byte valid.
- data_to_uart_node  out  DATA_WIDTH  byte to node UART.
- TX_use_node  out  1  one-cycle pulse, send byte.
- TX_flag_node  in  1  high = node UART TX busy.
- AUX  out  1  high = buffer empty and idle.
- fill_level  out  10  bytes currently stored.
- overflow  out  1  sticky, a byte was dropped.
REQ-006 SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-007 SHALL store each byte whose RX_flag_mcu pulse arrives while fill_level < FIFO512_DEPTH, in arrival order.
REQ-008 SHALL drop a byte that arrives while full, leave contents unchanged, and set overflow until reset.
REQ-009 SHALL implement FSM IDLE, COLLECT, DRAIN, WAIT_ACK.
REQ-010 IDLE -> COLLECT on first stored byte.
REQ-011 COLLECT -> DRAIN when fill_level >= START_WIRELESS_TRANS_VALUE, or when the idle counter reaches END_WAITING_SEND_WLESS_DATA-1.
REQ-012 Idle counter SHALL clear on every RX_flag_mcu pulse, increment each other COLLECT cycle, and hold at 0 outside COLLECT.
REQ-013 In DRAIN with fill_level > 0 and TX_flag_node low, SHALL drive the head byte on data_to_uart_node, pulse TX_use_node for exactly one cycle, pop it, and go to WAIT_ACK.
REQ-014 In DRAIN with TX_flag_node high, SHALL hold with no pulse.
REQ-015 WAIT_ACK SHALL wait one cycle, then return to DRAIN, so TX_flag_node can assert before the next byte.
REQ-016 data_to_uart_node SHALL hold stable from the TX_use_node pulse until the next pulse.
REQ-017 DRAIN -> IDLE when fill_level == 0.
REQ-018 Bytes written during DRAIN or WAIT_ACK SHALL be accepted and sent in the same drain.
REQ-019 On a write and a pop in the same cycle, fill_level SHALL stay unchanged; a write when full in that cycle SHALL be stored, not dropped.
REQ-020 Read and write pointers SHALL wrap modulo FIFO512_DEPTH.
REQ-021 fill_level SHALL range 0..FIFO512_DEPTH (10 bits covers 512).
REQ-022 AUX SHALL be high only in IDLE with fill_level == 0, as a registered output.

Reset
REQ-023 Reset SHALL set FSM to IDLE, pointers, fill_level and idle counter to 0, and TX_use_node, overflow and data_to_uart_node to 0; AUX SHALL be 1.
REQ-024 Reset mid-drain SHALL discard all buffered bytes, with no TX_use_node pulse in the reset-release cycle.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding and the default parameter values above.
REQ-026 Storage SHALL be one sub-module, sync_fifo_512 (single-clock FIFO: push, pop, full, empty, count); FSM and idle counter SHALL be in wless_tx_buffer.

Verification (sim params: depth 16, threshold 4, timeout 20)
REQ-027 Write 0x11,0x22,0x33,0x44 back-to-back, TX_flag_node low -> four TX_use_node pulses two cycles apart carrying 0x11..0x44 in order; AUX returns to 1.
REQ-028 Write 0xA5 only -> no pulse for 19 cycles after the write; 0xA5 sent once the timeout expires.
REQ-029 Write 17 bytes with TX_flag_node held high -> fill_level 16, overflow=1, 17th byte never sent.
REQ-030 Hold TX_flag_node high for 10 cycles during a drain -> no pulses while high; order preserved after release.
REQ-031 Write 0x5A in the same cycle as a pop at fill 16 -> fill_level stays 16, no overflow, 0x5A sent last.
REQ-032 Assert rst in WAIT_ACK with 3 bytes queued -> fill_level 0 and AUX 1 immediately; no further pulses.
